univ_shift_register: RTL
========================

# univ_shift_register

Parametrised universal shift register. It extends the fixed 4-bit load/shift/direction register to a configurable width, with five shift modes and a multi-position shift command. A start/busy/done handshake sequences the command one bit position per clock. It serves as the general-purpose serialiser and shifter for later lab datapaths, such as serial links and shift-and-add arithmetic.

## Interface
- WIDTH, 8: register width in bits; must be 2 or more.
- AMT_W, 4: width of the shift-amount field.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  parallel-load request; honoured only when idle.
- data_in  input  WIDTH  parallel load value.
- start  input  1  begin a shift command; honoured only when idle.
- mode  input  3  shift mode, sampled with start.
- amount  input  AMT_W  number of bit positions to shift, sampled with start.
- ser_in  input  1  serial fill bit for logical shifts, sampled on every shift edge.
- data_out  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted out of the register.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle pulse when a command completes.

## Operation
- Reset is synchronous and active-high: clk is the sole clock, and rst is sampled on its rising edge.
- Reset values: data_out=0, ser_out=0, busy=0, done=0, FSM=IDLE, step counter=0.
- FSM has two states, IDLE and SHIFT.
- IDLE, priority order:
  - rst first.
  - Then load: data_out<=data_in; start is ignored in that cycle.
  - Then start with amount=0: done<=1 for one cycle; data_out and ser_out unchanged; FSM stays in IDLE.
  - Then start with amount>0: latch mode and amount into internal registers, busy<=1, go to SHIFT.
- SHIFT: on each edge, perform one single-position step using the latched mode and decrement the counter.
  - On the edge that performs the final step: busy<=0, done<=1, return to IDLE.
- Modes (step applied to register value r):
  - 000 logical left: r<={r[W-2:0],ser_in}; ser_out<=r[W-1].
  - 001 logical right: r<={ser_in,r[W-1:1]}; ser_out<=r[0].
  - 010 rotate left: r<={r[W-2:0],r[W-1]}; ser_out<=r[W-1].
  - 011 rotate right: r<={r[0],r[W-1:1]}; ser_out<=r[0].
  - 100 arithmetic right: r<={r[W-1],r[W-1:1]}; ser_out<=r[0].
  - 101–111 reserved: register and ser_out hold; the command still runs for amount cycles and pulses done.
- amount may exceed WIDTH:
  - Rotates wrap modulo WIDTH.
  - Logical shifts keep filling with ser_in.
  - Arithmetic shift saturates to all-sign.
- During SHIFT:
  - load and start are ignored and dropped, not queued.
  - Changes on mode, amount or data_in have no effect.
- rst during SHIFT aborts the command: reset values apply and no done is produced.
- done is never high together with busy.
- A new start is accepted in the cycle where done=1, since the FSM is already in IDLE.

## Timing
- start sampled high at edge T with amount=N>0:
  - busy is high after edge T.
  - Steps occur at edges T+1 … T+N.
  - After edge T+N: busy=0, done=1, data_out final.
  - Total: N cycles busy, done in cycle N+1.
- amount=0: done is high for the one cycle after edge T; busy stays 0.
- load: data_out equals data_in one edge after load is sampled.
- Back-to-back: start held high across a done cycle launches the next command at that edge. Throughput is N+1 cycles per command.
- ser_out is registered and updates only on step edges; otherwise it holds.
- data_out and ser_out are combinational-free, driven directly from flops.

## Test plan
All cases use WIDTH=8, AMT_W=4.
- Reset/load: hold rst 2 cycles, then load=1 with data_in=0xA5 → all outputs 0 during reset, then data_out=0xA5 after one edge, busy=0, done=0.
- Rotate: from 0xA5, start with mode=010, amount=3 → busy high exactly 3 cycles, data_out=0x2D, done pulses once. Repeat with mode=011, amount=8 → data_out returns to its starting value.
- Arithmetic right: load 0x96, start with mode=100, amount=2 → data_out=0xE5, ser_out=1. Continue with amount=15 → data_out=0xFF.
- Logical left with fill: load 0x0F, ser_in=1, start with mode=000, amount=4 → data_out=0xFF, ser_out=0.
- Ignored requests and zero amount:
  - Assert load=1 (data_in=0x00) and start during busy → no effect; result as if absent.
  - start with amount=0 → done one cycle later, busy never high, data_out unchanged.
  - load and start together while idle → load wins.
- Reset mid-command: assert rst on the 2nd busy cycle of an amount=5 shift → data_out=0, busy=0, ser_out=0; no done pulse ever appears.

Source files
------------

// File: rtl/univ_shift_register.sv
// Parametrised universal shift register: parallel load plus five shift modes,
// executing a multi-position shift command one bit per clock.
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | accepts load/start; amount=0 starts complete here
  // SHIFT | one step per clock until the latched count runs out
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] step_data;
  logic             step_ser;

  // Single-position step for the latched mode; reserved modes hold.
  always_comb begin
    step_data = data_out;
    step_ser  = ser_out;
    case (mode_q)
      3'b000: begin
        step_data = {data_out[WIDTH-2:0], ser_in};
        step_ser  = data_out[WIDTH-1];
      end
      3'b001: begin
        step_data = {ser_in, data_out[WIDTH-1:1]};
        step_ser  = data_out[0];
      end
      3'b010: begin
        step_data = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
        step_ser  = data_out[WIDTH-1];
      end
      3'b011: begin
        step_data = {data_out[0], data_out[WIDTH-1:1]};
        step_ser  = data_out[0];
      end
      3'b100: begin
        step_data = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
        step_ser  = data_out[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= '0;
      ser_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_q   <= 3'b000;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            data_out <= data_in;
          end else if (start) begin
            if (amount == '0) begin
              done <= 1'b1;
            end else begin
              mode_q <= mode;
              cnt    <= amount;
              busy   <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_out <= step_data;
          ser_out  <= step_ser;
          cnt      <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
